// File: rtl/lsu_if.sv
// Bundles the signals between the load/store unit, the core and the data-side
// memory targets (on-chip RAM and I/O region).
//   slave  : the LSU itself. It receives core requests and target responses, and
//            drives the completion and the bus request.
//   master : the environment around the LSU (core + targets).
// Core side : valid_i/ready_o handshake, we_i, addr_i, wdata_i, hb_i, uload_i
//             in; done_o, err_o, err_code_o, rdata_o out.
// Bus side  : mem_req_o, mem_ce_ram_o, mem_ce_io_o, mem_addr_o, mem_wdata_o,
//             mem_we_o, mem_hb_o, mem_uload_o out; per-target grant and read
//             data in.
interface lsu_if;
  logic        valid_i;
  logic        ready_o;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  hb_i;
  logic        uload_i;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic [31:0] rdata_o;

  logic        mem_req_o;
  logic        mem_ce_ram_o;
  logic        mem_ce_io_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_we_o;
  logic [1:0]  mem_hb_o;
  logic        mem_uload_o;
  logic        mem_gnt_ram_i;
  logic        mem_gnt_io_i;
  logic [31:0] mem_rdata_ram_i;
  logic [31:0] mem_rdata_io_i;

  modport slave (
    input  valid_i, we_i, addr_i, wdata_i, hb_i, uload_i,
    input  mem_gnt_ram_i, mem_gnt_io_i, mem_rdata_ram_i, mem_rdata_io_i,
    output ready_o, done_o, err_o, err_code_o, rdata_o,
    output mem_req_o, mem_ce_ram_o, mem_ce_io_o, mem_addr_o, mem_wdata_o,
    output mem_we_o, mem_hb_o, mem_uload_o
  );

  modport master (
    output valid_i, we_i, addr_i, wdata_i, hb_i, uload_i,
    output mem_gnt_ram_i, mem_gnt_io_i, mem_rdata_ram_i, mem_rdata_io_i,
    input  ready_o, done_o, err_o, err_code_o, rdata_o,
    input  mem_req_o, mem_ce_ram_o, mem_ce_io_o, mem_addr_o, mem_wdata_o,
    input  mem_we_o, mem_hb_o, mem_uload_o
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: accepts one memory operation at a time from the execute
// stage, checks size encoding and alignment, decodes the address into a RAM or
// I/O chip enable, holds the request stable until the selected target grants
// (or a timeout expires), extends load data and returns a registered
// one-cycle completion.
// Ports:
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : lsu_if.slave (core handshake + memory bus, see lsu_if.sv)
module lsu #(
  parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
  parameter int          RAM_BYTES = 8192,
  parameter logic [31:0] IO_BASE   = 32'h8000_0000,
  parameter int          IO_BYTES  = 4096,
  parameter int          TIMEOUT   = 16
) (
  input logic  clk_i,
  input logic  rst_ni,
  lsu_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_DECODE   = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_t;

  localparam int          CW       = $clog2(TIMEOUT + 1);
  localparam logic [31:0] RAM_MASK = 32'(RAM_BYTES - 1);
  localparam logic [31:0] IO_MASK  = 32'(IO_BYTES - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt, wait_cnt_next;

  // Latched operation fields, driven straight onto the bus.
  logic        op_we;
  logic [31:0] op_offset;
  logic [31:0] op_wdata;
  logic [1:0]  op_hb;
  logic        op_uload;
  logic        sel_ram;
  logic        sel_io;

  // Registered completion outputs and their next values.
  logic        done_q, done_d;
  logic        err_q, err_d;
  err_t        code_q, code_d;
  logic [31:0] rdata_q, rdata_d;

  // Accept-time decode.
  logic        accept;
  logic        hit_ram, hit_io;
  logic        misalign;
  err_t        accept_code;
  logic [31:0] accept_offset;

  // WAIT-time response.
  logic        gnt_sel;
  logic [31:0] rdata_sel;
  logic [31:0] load_ext;

  assign accept  = bus.valid_i && (state == S_IDLE);
  assign hit_ram = (bus.addr_i & ~RAM_MASK) == RAM_BASE;
  assign hit_io  = (bus.addr_i & ~IO_MASK) == IO_BASE;

  assign misalign = ((bus.hb_i == 2'b10) && (bus.addr_i[1:0] != 2'b00)) ||
                    ((bus.hb_i == 2'b01) && bus.addr_i[0]);

  // Priority: illegal size, then alignment, then address decode.
  always_comb begin
    if (bus.hb_i == 2'b11)      accept_code = ERR_DECODE;
    else if (misalign)          accept_code = ERR_MISALIGN;
    else if (!hit_ram && !hit_io) accept_code = ERR_DECODE;
    else                        accept_code = ERR_NONE;
  end

  assign accept_offset = hit_ram ? (bus.addr_i - RAM_BASE) : (bus.addr_i - IO_BASE);

  // Only the selected target's grant counts; the other one is ignored.
  assign gnt_sel   = (sel_ram && bus.mem_gnt_ram_i) || (sel_io && bus.mem_gnt_io_i);
  assign rdata_sel = sel_ram ? bus.mem_rdata_ram_i : bus.mem_rdata_io_i;

  always_comb begin
    unique case (op_hb)
      2'b00:   load_ext = {{24{~op_uload & rdata_sel[7]}}, rdata_sel[7:0]};
      2'b01:   load_ext = {{16{~op_uload & rdata_sel[15]}}, rdata_sel[15:0]};
      default: load_ext = rdata_sel;
    endcase
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves a value unassigned and infers a latch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    done_d        = 1'b0;
    err_d         = 1'b0;
    code_d        = ERR_NONE;
    rdata_d       = '0;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          wait_cnt_next = '0;
          if (accept_code != ERR_NONE) begin
            state_next = S_DONE;
            done_d     = 1'b1;
            err_d      = 1'b1;
            code_d     = accept_code;
          end else begin
            state_next = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        wait_cnt_next = wait_cnt + 1'b1;
        // Grant is checked first so a grant in the timeout cycle still wins.
        if (gnt_sel) begin
          state_next = S_DONE;
          done_d     = 1'b1;
          rdata_d    = op_we ? 32'h0 : load_ext;
        end else if (wait_cnt_next == CW'(TIMEOUT)) begin
          state_next = S_DONE;
          done_d     = 1'b1;
          err_d      = 1'b1;
          code_d     = ERR_TIMEOUT;
        end
      end

      S_DONE: state_next = S_IDLE;

      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      rdata_q   <= '0;
      op_we     <= 1'b0;
      op_offset <= '0;
      op_wdata  <= '0;
      op_hb     <= 2'b00;
      op_uload  <= 1'b0;
      sel_ram   <= 1'b0;
      sel_io    <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      done_q   <= done_d;
      err_q    <= err_d;
      code_q   <= code_d;
      rdata_q  <= rdata_d;
      if (accept) begin
        op_we     <= bus.we_i;
        op_offset <= accept_offset;
        op_wdata  <= bus.wdata_i;
        op_hb     <= bus.hb_i;
        op_uload  <= bus.uload_i;
        // A rejected op selects no target, so it never touches the bus.
        sel_ram   <= (accept_code == ERR_NONE) && hit_ram;
        sel_io    <= (accept_code == ERR_NONE) && !hit_ram && hit_io;
      end
    end
  end

  // Request and chip enables follow the state register directly, so an
  // asynchronous reset drops them immediately.
  assign bus.ready_o      = (state == S_IDLE);
  assign bus.mem_req_o    = (state == S_WAIT);
  assign bus.mem_ce_ram_o = (state == S_WAIT) && sel_ram;
  assign bus.mem_ce_io_o  = (state == S_WAIT) && sel_io;
  assign bus.mem_addr_o   = op_offset;
  assign bus.mem_wdata_o  = op_wdata;
  assign bus.mem_we_o     = op_we;
  assign bus.mem_hb_o     = op_hb;
  assign bus.mem_uload_o  = op_uload;

  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;
  assign bus.err_code_o = code_q;
  assign bus.rdata_o    = rdata_q;

endmodule
